gpio_bidir_seq: RTL



---
 rtl/gpio_pkg.sv | 45 ++++
 rtl/gpio_bidir_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pkg
// Description : Shared types and constants for the bidirectional GPIO pad
//               sequencer. Holds the sequencer state encoding, the default
//               pad bus width and small state-decode helpers used by the
//               sequencer.
// Contents    : gpio_state_e   - sequencer state encoding
//               GPIO_W         - default pad bus width
//               state_is_idle  - 1 in states that accept a command
//               state_drives   - 1 in states where the pad is driven
// Revision    : 1.0  initial release
// ============================================================================
package gpio_pkg;

    // Default width of the pad bank handled by one sequencer.
    localparam int GPIO_W = 8;

    // IDLE_IN  : bus released, ready for a command.
    // IDLE_OUT : bus driven with the last written data, ready for a command.
    // TURN_OUT : released, waiting for the far end to stop driving.
    // TURN_IN  : released after driving, waiting before sampling.
    // DRIVE    : driving freshly written data for the minimum hold time.
    // SETTLE   : released, letting the pad and input register settle.
    typedef enum logic [2:0] {
        IDLE_IN  = 3'd0,
        IDLE_OUT = 3'd1,
        TURN_OUT = 3'd2,
        TURN_IN  = 3'd3,
        DRIVE    = 3'd4,
        SETTLE   = 3'd5
    } gpio_state_e;

    // States in which a new command may be accepted.
    function automatic logic state_is_idle(input gpio_state_e s);
        return (s == IDLE_IN) || (s == IDLE_OUT);
    endfunction

    // States in which the pad buffer is enabled.
    function automatic logic state_drives(input gpio_state_e s);
        return (s == DRIVE) || (s == IDLE_OUT);
    endfunction

endpackage : gpio_pkg
`default_nettype wire

// File: rtl/gpio_bidir_seq.sv
`default_nettype none
// ============================================================================
// Module      : gpio_bidir_seq
// Description : Command sequencer for one bidirectional GPIO pad bank sitting
//               in front of the IOBUF wrapper. Accepts single read/write
//               commands, inserts turnaround cycles on every change of bus
//               direction, holds written data on the pad, and returns read
//               data after a settle delay. The pad is released (gpio_t_o=1)
//               whenever the far end may still be driving it, and is released
//               immediately when reset is asserted.
// Ports       : clk, rst_n            - clock, asynchronous active-low reset
//               cmd_valid/cmd_ready   - command handshake
//               cmd_write, cmd_wdata  - command kind and write data
//               rsp_valid, rsp_rdata  - single-cycle read-data strobe + data
//               busy                  - high outside the two idle states
//               gpio_dout_o           - data to wrapper din_i
//               gpio_t_o              - to wrapper in_not_out_i (1=released)
//               gpio_din_i            - registered pad data from wrapper dout_o
// Revision    : 1.0  initial release
// ============================================================================
module gpio_bidir_seq
    import gpio_pkg::*;
#(
    parameter int WIDTH      = GPIO_W,
    parameter int TURN_CYC   = 2,
    parameter int HOLD_CYC   = 1,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [WIDTH-1:0] cmd_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             busy,
    output logic [WIDTH-1:0] gpio_dout_o,
    output logic             gpio_t_o,
    input  logic [WIDTH-1:0] gpio_din_i
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------------
    generate
        if (HOLD_CYC < 1) begin : g_bad_hold
            $error("gpio_bidir_seq: HOLD_CYC must be >= 1");
        end
        if (SETTLE_CYC < 1) begin : g_bad_settle
            $error("gpio_bidir_seq: SETTLE_CYC must be >= 1");
        end
        if (TURN_CYC < 0) begin : g_bad_turn
            $error("gpio_bidir_seq: TURN_CYC must be >= 0");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Shared down-counter sizing. Each timed state loads N-1 on entry and
    // leaves when the count reaches 0, so the counter only has to hold
    // max(N)-1.
    // ------------------------------------------------------------------------
    localparam int C_MAX_A = (TURN_CYC > HOLD_CYC) ? TURN_CYC : HOLD_CYC;
    localparam int C_MAX   = (C_MAX_A > SETTLE_CYC) ? C_MAX_A : SETTLE_CYC;
    localparam int CNT_W   = (C_MAX > 1) ? $clog2(C_MAX) : 1;

    localparam logic [CNT_W-1:0] C_TURN_LOAD   =
        CNT_W'((TURN_CYC > 0) ? (TURN_CYC - 1) : 0);
    localparam logic [CNT_W-1:0] C_HOLD_LOAD   =
        CNT_W'((HOLD_CYC > 0) ? (HOLD_CYC - 1) : 0);
    localparam logic [CNT_W-1:0] C_SETTLE_LOAD =
        CNT_W'((SETTLE_CYC > 0) ? (SETTLE_CYC - 1) : 0);

    // Turnaround state is bypassed entirely when TURN_CYC is zero.
    localparam logic C_HAS_TURN = (TURN_CYC > 0);

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    gpio_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_t;
    logic [WIDTH-1:0] r_dout;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_rdata;

    logic             w_cnt_last;
    logic             w_accept;

    assign w_cnt_last = (r_cnt == '0);
    assign w_accept   = cmd_valid && state_is_idle(r_state);

    // r_t is kept equal to !state_drives(r_state) at all times: every
    // transition below sets it together with the next state, so the pad
    // enable is a flop output rather than a state decode. Its asynchronous
    // reset to 1 releases the pad the instant rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE_IN;
            r_cnt       <= '0;
            r_t         <= 1'b1;
            r_dout      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;

            case (r_state)
                IDLE_IN: begin
                    if (w_accept) begin
                        if (cmd_write) begin
                            r_dout <= cmd_wdata;
                            if (C_HAS_TURN) begin
                                // Far end may still drive: wait released.
                                r_state <= TURN_OUT;
                                r_cnt   <= C_TURN_LOAD;
                            end else begin
                                r_state <= DRIVE;
                                r_cnt   <= C_HOLD_LOAD;
                                r_t     <= 1'b0;
                            end
                        end else begin
                            // Already released: go straight to settling.
                            r_state <= SETTLE;
                            r_cnt   <= C_SETTLE_LOAD;
                        end
                    end
                end

                IDLE_OUT: begin
                    if (w_accept) begin
                        if (cmd_write) begin
                            // Same direction: no turnaround needed.
                            r_dout  <= cmd_wdata;
                            r_state <= DRIVE;
                            r_cnt   <= C_HOLD_LOAD;
                        end else begin
                            r_t <= 1'b1;
                            if (C_HAS_TURN) begin
                                r_state <= TURN_IN;
                                r_cnt   <= C_TURN_LOAD;
                            end else begin
                                r_state <= SETTLE;
                                r_cnt   <= C_SETTLE_LOAD;
                            end
                        end
                    end
                end

                TURN_OUT: begin
                    if (w_cnt_last) begin
                        r_state <= DRIVE;
                        r_cnt   <= C_HOLD_LOAD;
                        r_t     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                TURN_IN: begin
                    if (w_cnt_last) begin
                        r_state <= SETTLE;
                        r_cnt   <= C_SETTLE_LOAD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                DRIVE: begin
                    if (w_cnt_last) begin
                        // Keep driving the last data until a read arrives.
                        r_state <= IDLE_OUT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                SETTLE: begin
                    if (w_cnt_last) begin
                        // gpio_din_i is already registered by the wrapper;
                        // the settle window covers that register stage.
                        r_rsp_rdata <= gpio_din_i;
                        r_rsp_valid <= 1'b1;
                        r_state     <= IDLE_IN;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                default: begin
                    // Unused encodings recover to the safe, released idle.
                    r_state <= IDLE_IN;
                    r_cnt   <= '0;
                    r_t     <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign cmd_ready   = state_is_idle(r_state);
    assign busy        = !state_is_idle(r_state);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign gpio_dout_o = r_dout;
    assign gpio_t_o    = r_t;

endmodule : gpio_bidir_seq
`default_nettype wire
